// File: rtl/prime_sweep_ctrl.sv
// prime_sweep_ctrl: sweeps a code range [lo, hi] through the 4-to-16 decoder /
// prime-flag stage. Each code is held for DWELL cycles. The prime flag is then
// sampled, and a per-code prime bitmap and a prime count are accumulated.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, lo, hi       sweep request and range (sampled in IDLE only)
//   code_out, en_out    decoder select code and enable
//   prime_in            decoder prime flag (combinational from code_out/en_out)
//   busy, done, err     handshake: sweep in progress, end pulse, rejected range
//   prime_count         number of sampled codes flagged prime
//   prime_mask          bit k set when code k was sampled as prime
module prime_sweep_ctrl #(
    parameter int unsigned DWELL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  lo,
    input  logic [3:0]  hi,
    output logic [3:0]  code_out,
    output logic        en_out,
    input  logic        prime_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [4:0]  prime_count,
    output logic [15:0] prime_mask
);

    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned DW_W   = 4;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CODE_W-1:0]   r_code,  w_code_nxt;
    logic [CODE_W-1:0]   r_hi,    w_hi_nxt;
    logic [DW_W-1:0]     r_dwell, w_dwell_nxt;
    logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
    logic [MASK_W-1:0]   r_mask,  w_mask_nxt;
    logic                r_en,    w_en_nxt;
    logic                r_busy,  w_busy_nxt;
    logic                r_done,  w_done_nxt;
    logic                r_err,   w_err_nxt;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_code  <= '0;
            r_hi    <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_hi    <= w_hi_nxt;
            r_dwell <= w_dwell_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_hi_nxt    = r_hi;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_en_nxt    = r_en;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mask_nxt = '0;
                    w_cnt_nxt  = '0;
                    if (lo <= hi) begin
                        w_hi_nxt    = hi;
                        w_err_nxt   = 1'b0;
                        w_code_nxt  = lo;
                        w_en_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_dwell_nxt = '0;
                        w_state_nxt = S_SWEEP;
                    end else begin
                        // Rejected range: no code is driven, just the done pulse
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_FINISH;
                    end
                end
            end

            S_SWEEP: begin
                if (r_dwell != DWELL_LAST) begin
                    w_dwell_nxt = r_dwell + DW_W'(1);
                end else begin
                    if (prime_in) begin
                        w_mask_nxt = r_mask | (MASK_W'(1) << r_code);
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                    end
                    // Stop on hi rather than wrapping, so code 15 is the last code
                    if (r_code != r_hi) begin
                        w_code_nxt  = r_code + CODE_W'(1);
                        w_dwell_nxt = '0;
                    end else begin
                        w_en_nxt    = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_FINISH;
                    end
                end
            end

            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign code_out    = r_code;
    assign en_out      = r_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign prime_count = r_cnt;
    assign prime_mask  = r_mask;

endmodule

// File: tb/tb_prime_sweep_ctrl.sv
// Bench for prime_sweep_ctrl. Two instances (DWELL=1 and DWELL=3) share the
// request inputs. Each drives its own decoder model built from a prime table.
// The DWELL=3 instance sees random prime_in on non-sample cycles.
module tb_prime_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  lo;
    logic [3:0]  hi;

    logic [3:0]  code1, code3;
    logic        en1, en3, busy1, busy3, done1, done3, err1, err3;
    logic [4:0]  cnt1, cnt3;
    logic [15:0] mask1, mask3;
    logic        prime1, prime3;

    logic [15:0] tbl;
    logic        noise_en3;
    logic        noise_val3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_code;

    prime_sweep_ctrl #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .code_out(code1), .en_out(en1), .prime_in(prime1),
        .busy(busy1), .done(done1), .err(err1),
        .prime_count(cnt1), .prime_mask(mask1)
    );

    prime_sweep_ctrl #(.DWELL(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
        .code_out(code3), .en_out(en3), .prime_in(prime3),
        .busy(busy3), .done(done3), .err(err3),
        .prime_count(cnt3), .prime_mask(mask3)
    );

    // Decoder models: prime flag looked up from the table while enabled
    assign prime1 = en1 & tbl[code1];
    assign prime3 = noise_en3 ? noise_val3 : (en3 & tbl[code3]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_mask(input logic [3:0] l, input logic [3:0] h,
                                               input logic [15:0] t);
        logic [15:0] m;
        m = '0;
        for (int k = 0; k < 16; k++)
            if (k >= int'(l) && k <= int'(h) && t[k]) m[k] = 1'b1;
        return m;
    endfunction

    function automatic int popcount(input logic [15:0] m);
        int s;
        s = 0;
        for (int k = 0; k < 16; k++) s += int'(m[k]);
        return s;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " code1"}, 32'(code1), 32'd0);
        check({pfx, " en1"},   32'(en1),   32'd0);
        check({pfx, " busy1"}, 32'(busy1), 32'd0);
        check({pfx, " done1"}, 32'(done1), 32'd0);
        check({pfx, " err1"},  32'(err1),  32'd0);
        check({pfx, " cnt1"},  32'(cnt1),  32'd0);
        check({pfx, " mask1"}, 32'(mask1), 32'd0);
        check({pfx, " code3"}, 32'(code3), 32'd0);
        check({pfx, " en3"},   32'(en3),   32'd0);
        check({pfx, " busy3"}, 32'(busy3), 32'd0);
        check({pfx, " cnt3"},  32'(cnt3),  32'd0);
        check({pfx, " mask3"}, 32'(mask3), 32'd0);
    endtask

    // One request plus 56 observed cycles; compared against the range model
    task automatic run_sweep(input logic [3:0] l, input logic [3:0] h, input bit intrude);
        int n, lat1, lat3, pul1, pul3, bsy1, bsy3, enc1, enc3;
        int e_lat1, e_lat3;
        logic [15:0] e_mask;
        string s;
        n    = (l <= h) ? int'(h) - int'(l) + 1 : 0;
        lat1 = -1; lat3 = -1;
        pul1 = 0; pul3 = 0; bsy1 = 0; bsy3 = 0; enc1 = 0; enc3 = 0;
        for (int c = 0; c < 56; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b1; lo = l; hi = h;
            end else if (intrude && c == 3) begin
                start = 1'b1; lo = 4'd0; hi = 4'd1;
            end else begin
                start = 1'b0; lo = 4'($urandom); hi = 4'($urandom);
            end
            noise_en3  = (c % 3 != 0);
            noise_val3 = 1'($urandom);
            @(posedge clk);
            #1;
            if (done1) begin pul1++; if (lat1 < 0) lat1 = c; end
            if (done3) begin pul3++; if (lat3 < 0) lat3 = c; end
            if (busy1) bsy1++;
            if (busy3) bsy3++;
            if (en1) enc1++;
            if (en3) enc3++;
        end
        start = 1'b0;
        noise_en3 = 1'b0;

        e_mask = model_mask(l, h, tbl);
        e_lat1 = (n > 0) ? n + 1 : 1;
        e_lat3 = (n > 0) ? 3 * n + 1 : 1;
        if (n > 0) exp_code = h;
        s = $sformatf("[%0d..%0d]", l, h);

        check({s, " d1 latency"}, 32'(lat1), 32'(e_lat1));
        check({s, " d3 latency"}, 32'(lat3), 32'(e_lat3));
        check({s, " d1 pulses"},  32'(pul1), 32'd1);
        check({s, " d3 pulses"},  32'(pul3), 32'd1);
        check({s, " d1 busy cyc"}, 32'(bsy1), 32'(n));
        check({s, " d3 busy cyc"}, 32'(bsy3), 32'(3 * n));
        check({s, " d1 en cyc"},  32'(enc1), 32'(n));
        check({s, " d3 en cyc"},  32'(enc3), 32'(3 * n));
        check({s, " d1 mask"},    32'(mask1), 32'(e_mask));
        check({s, " d3 mask"},    32'(mask3), 32'(e_mask));
        check({s, " d1 count"},   32'(cnt1), 32'(popcount(e_mask)));
        check({s, " d3 count"},   32'(cnt3), 32'(popcount(e_mask)));
        check({s, " d1 err"},     32'(err1), 32'(l > h));
        check({s, " d3 err"},     32'(err3), 32'(l > h));
        check({s, " d1 code end"}, 32'(code1), 32'(exp_code));
        check({s, " d3 code end"}, 32'(code3), 32'(exp_code));
    endtask

    // Abort a full sweep with rst after five cycles, then watch for a stray done
    task automatic run_reset_abort();
        int pul;
        @(negedge clk);
        start = 1'b1; lo = 4'd0; hi = 4'd15;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        exp_code = 4'd0;
        pul = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done1 || done3) pul++;
        end
        check("abort no done", 32'(pul), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; lo = '0; hi = '0;
        noise_en3 = 1'b0; noise_val3 = 1'b0;
        tbl = 16'h28AC;
        exp_code = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with the real prime table
        run_sweep(4'd0, 4'd15, 1'b0);
        check("full mask const", 32'(mask1), 32'h28AC);
        check("full count const", 32'(cnt1), 32'd6);
        run_sweep(4'd7, 4'd7, 1'b0);
        check("single 7 mask const", 32'(mask1), 32'h0080);
        run_sweep(4'd9, 4'd9, 1'b0);
        run_sweep(4'd9, 4'd4, 1'b0);
        check("reject err const", 32'(err1), 32'd1);
        run_sweep(4'd0, 4'd15, 1'b0);
        run_sweep(4'd2, 4'd3, 1'b0);
        check("dwell3 mask const", 32'(mask3), 32'h000C);
        run_sweep(4'd4, 4'd8, 1'b1);
        check("intrude mask const", 32'(mask1), 32'h00A0);

        run_reset_abort();
        run_sweep(4'd0, 4'd15, 1'b0);

        // Random ranges and random prime tables
        for (int i = 0; i < 20; i++) begin
            tbl = 16'($urandom);
            run_sweep(4'($urandom), 4'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
